invsqrt_result_collector: RTL

- Receiving end of the invsqrt_pipeline output interface.
- Consumes the pipeline's 31-bit result stream (pipe_ready / pipe_result) and restores the 32-bit IEEE-754 single with sign bit 0.
- Buffers results in a small FIFO and presents them downstream on a valid/ready stream with burst framing.
- Drives the pipeline clock-enable, so a full FIFO stalls the pipeline instead of losing results.

---
 rtl/invsqrt_result_collector.sv | 112 +++++++++++
 1 files changed

// File: rtl/invsqrt_result_collector.sv
// Collects invsqrt_pipeline results into a FIFO and streams them downstream with burst framing.
// Optional statistics counters are enabled by defining INVSQRT_COLLECT_STATS_EN.
module invsqrt_result_collector #(
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce_in,
  output logic                   pipe_ce,
  input  logic                   pipe_ready,
  input  logic [30:0]            pipe_result,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [31:0]            m_data,
  output logic                   m_last,
  output logic                   m_special,
  output logic [$clog2(DEPTH):0] level,
  output logic                   stalled
`ifdef INVSQRT_COLLECT_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [31:0]            stat_results,
  output logic [31:0]            stat_stalls
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  logic [30:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   burst_q, burst_d;
  logic          full, push, pop;
  logic [30:0]   head;

  // Stalling via pipe_ce (never via m_ready) keeps the upstream path free of downstream timing.
  assign full    = (level_q == LW'(DEPTH));
  assign pipe_ce = ce_in & ~full & rst_n;
  assign stalled = ce_in & full;
  assign push    = pipe_ce & pipe_ready;
  assign m_valid = (level_q != '0);
  assign pop     = m_valid & m_ready;
  assign level   = level_q;

  // Head fields are masked while empty so stale storage never leaks onto the outputs.
  assign head      = mem_q[rd_ptr_q];
  assign m_data    = m_valid ? {1'b0, head} : 32'h0;
  assign m_last    = m_valid & (burst_q == LAST_IDX);
  assign m_special = m_valid & ((&head[30:23]) | ~(|head[30:23]));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    burst_d  = burst_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      burst_d  = (burst_q == LAST_IDX) ? 16'h0 : burst_q + 16'h1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      burst_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      burst_q  <= burst_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; level_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pipe_result;
  end

`ifdef INVSQRT_COLLECT_STATS_EN
  logic [31:0] stat_results_q, stat_stalls_q;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_results_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      if (push && stat_results_q != '1)   stat_results_q <= stat_results_q + 32'h1;
      if (stalled && stat_stalls_q != '1) stat_stalls_q  <= stat_stalls_q + 32'h1;
    end
  end

  assign stat_results = stat_results_q;
  assign stat_stalls  = stat_stalls_q;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule
